wrrn_arbit: RTL and testbench



---
 rtl/wrrn_arbit.sv | 145 ++++++++++++++
 tb/tb_wrrn_arbit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrrn_arbit.sv
// wrrn_arbit: N-channel weighted round-robin arbiter with per-channel credit counters.
// Define WRR_BURST_EN to keep the pointer on a channel until its credits run out (burst order).
module wrrn_arbit #(
  parameter  int N     = 4,
  parameter  int WT_W  = 5,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [N-1:0]      req,
  input  logic [N*WT_W-1:0] wt,
  input  logic              gnt_busy,
  output logic              gnt_val,
  output logic [N-1:0]      gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    ARB  = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [N-1:0]                req_q, req_d;
  logic [N-1:0][WT_W-1:0]      wt_q, wt_d;
  logic [N-1:0][WT_W-1:0]      cred_q, cred_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic                        gnt_val_q, gnt_val_d;
  logic [N-1:0]                gnt_q, gnt_d;
  logic [IDX_W-1:0]            gnt_idx_q, gnt_idx_d;

  logic [N-1:0]                eligible;
  logic [N-1:0]                cred_avail;
  logic [N-1:0]                cand;
  logic                        any_elig;
  logic                        exhausted;
  logic [IDX_W-1:0]            sel;
  logic [IDX_W-1:0]            sel_next;
  logic [WT_W-1:0]             sel_cred;

  // Rotating first-match search starting at ptr. When no eligible channel has
  // credit left the round is exhausted and the search runs over a virtual reload.
  always_comb begin : sel_logic
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] pos_i;
    logic             found;
    for (int i = 0; i < N; i++) begin
      eligible[i]   = req_q[i] && (wt_q[i] != '0);
      cred_avail[i] = eligible[i] && (cred_q[i] != '0);
    end
    any_elig  = |eligible;
    exhausted = ~|cred_avail;
    cand      = exhausted ? eligible : cred_avail;

    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      pos_i = pos[IDX_W-1:0];
      if (!found && cand[pos_i]) begin
        found = 1'b1;
        sel   = pos_i;
      end
    end

    // Never underflows: a zero-credit channel is only picked after a reload.
    sel_cred = (exhausted ? wt_q[sel] : cred_q[sel]) - WT_W'(1);
    sel_next = (sel == IDX_W'(N-1)) ? '0 : sel + IDX_W'(1);
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin : next_logic
    state_d   = state_q;
    req_d     = req_q;
    wt_d      = wt_q;
    cred_d    = cred_q;
    ptr_d     = ptr_q;
    gnt_val_d = 1'b0;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;

    case (state_q)
      IDLE: begin
        if (req_val) begin
          req_d   = req;
          wt_d    = wt;
          state_d = ARB;
        end
      end
      ARB: begin
        if (!any_elig) begin
          state_d = IDLE;
        end else if (!gnt_busy) begin
          gnt_val_d  = 1'b1;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          gnt_idx_d  = sel;
          if (exhausted) cred_d = wt_q;
          cred_d[sel] = sel_cred;
`ifdef WRR_BURST_EN
          ptr_d = (sel_cred != '0) ? sel : sel_next;
`else
          ptr_d = sel_next;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // value of its _d input regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      wt_q      <= '0;
      cred_q    <= '0;
      ptr_q     <= '0;
      gnt_val_q <= 1'b0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wt_q      <= wt_d;
      cred_q    <= cred_d;
      ptr_q     <= ptr_d;
      gnt_val_q <= gnt_val_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign req_rdy = (state_q == IDLE);
  assign gnt_val = gnt_val_q;
  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_wrrn_arbit.sv
// tb_wrrn_arbit: self-checking bench for wrrn_arbit (N=4 and N=2 instances) with a
// transaction-level credit/round model; builds in either WRR_BURST_EN mode.
module tb_wrrn_arbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic        a_req_val, a_busy, a_rdy, a_gnt_val;
  logic [3:0]  a_req, a_gnt;
  logic [19:0] a_wt;
  logic [1:0]  a_idx;
  // N=2 instance
  logic        b_req_val, b_busy, b_rdy, b_gnt_val;
  logic [1:0]  b_req, b_gnt;
  logic [9:0]  b_wt;
  logic [0:0]  b_idx;

  wrrn_arbit #(.N(4), .WT_W(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_val(a_req_val), .req_rdy(a_rdy), .req(a_req),
    .wt(a_wt), .gnt_busy(a_busy), .gnt_val(a_gnt_val), .gnt(a_gnt), .gnt_idx(a_idx)
  );

  wrrn_arbit #(.N(2), .WT_W(5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_val(b_req_val), .req_rdy(b_rdy), .req(b_req),
    .wt(b_wt), .gnt_busy(b_busy), .gnt_val(b_gnt_val), .gnt(b_gnt), .gnt_idx(b_idx)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: credits per channel and the round-robin start point.
  int m_cred[4];
  int m_ptr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_cred[i] = 0;
    m_ptr = 0;
  endfunction

  // One committed grant under the weighted round-robin rules; -1 if nobody eligible.
  function automatic int model_commit(input int n, input logic [3:0] r, input logic [19:0] w);
    int  wv[4];
    bit  elig[4];
    int  s;
    int  c;
    s = -1;
    for (int i = 0; i < n; i++) begin
      wv[i]   = int'(w[i*5 +: 5]);
      elig[i] = r[i] && (wv[i] != 0);
    end
    for (int k = 0; k < n; k++) begin
      c = (m_ptr + k) % n;
      if (s < 0 && elig[c] && m_cred[c] > 0) s = c;
    end
    if (s < 0) begin
      for (int k = 0; k < n; k++) begin
        c = (m_ptr + k) % n;
        if (s < 0 && elig[c]) s = c;
      end
      if (s >= 0) for (int i = 0; i < n; i++) m_cred[i] = wv[i];
    end
    if (s < 0) return -1;
    m_cred[s] = m_cred[s] - 1;
`ifdef WRR_BURST_EN
    m_ptr = (m_cred[s] != 0) ? s : (s + 1) % n;
`else
    m_ptr = (s + 1) % n;
`endif
    return s;
  endfunction

  task automatic drive(input bit use2, input logic v, input logic [3:0] r,
                       input logic [19:0] w, input logic busy);
    if (use2) begin
      b_req_val = v; b_req = r[1:0]; b_wt = w[9:0]; b_busy = busy;
    end else begin
      a_req_val = v; a_req = r; a_wt = w; a_busy = busy;
    end
  endtask

  task automatic get(input bit use2, output logic gv, output logic rdy,
                     output logic [3:0] g, output logic [31:0] idx);
    if (use2) begin
      gv = b_gnt_val; rdy = b_rdy; g = {2'b00, b_gnt}; idx = 32'(b_idx);
    end else begin
      gv = a_gnt_val; rdy = a_rdy; g = a_gnt; idx = 32'(a_idx);
    end
  endtask

  // Called at a negedge; returns at the negedge where the grant (if any) is visible.
  task automatic xact(input bit use2, input logic [3:0] r, input logic [19:0] w,
                      input int stall, input int exp_sel, input string tag,
                      output int got_sel);
    logic        gv, rdy;
    logic [3:0]  g;
    logic [31:0] idx;
    drive(use2, 1'b1, r, w, 1'b0);
    @(negedge clk);
    get(use2, gv, rdy, g, idx);
    check({tag, "_rdy_arb"}, 32'(rdy), 0);
    check({tag, "_val_pulse"}, 32'(gv), 0);
    for (int s = 0; s < stall; s++) begin
      drive(use2, 1'b1, ~r, 20'($urandom), 1'b1);
      @(negedge clk);
      get(use2, gv, rdy, g, idx);
      check({tag, "_stall_val"}, 32'(gv), 0);
      check({tag, "_stall_rdy"}, 32'(rdy), 0);
    end
    drive(use2, 1'b0, r, w, 1'b0);
    @(negedge clk);
    get(use2, gv, rdy, g, idx);
    check({tag, "_val"}, 32'(gv), 32'(exp_sel >= 0));
    check({tag, "_rdy_back"}, 32'(rdy), 1);
    if (exp_sel >= 0) begin
      check({tag, "_gnt"}, 32'(g), 32'(1 << exp_sel));
      check({tag, "_idx"}, idx, 32'(exp_sel));
    end
    got_sel = gv ? int'(idx) : -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 20'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 20'h0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [19:0] wt;
    int          stall;
    int          exp_sel;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    int          exp6[6];
    int          got;
    int          e;
    int          cnt[2];
    logic [19:0] w;
    logic [3:0]  r;

`ifdef WRR_BURST_EN
    exp6 = '{0, 0, 0, 0, 1, 1};
`else
    exp6 = '{0, 1, 0, 1, 0, 0};
`endif
    // Fresh after reset: round starts exhausted, first eligible from channel 0.
    tbl[0] = '{4'b0100, {5'd0,  5'd3, 5'd0, 5'd0}, 0,  2};
    tbl[1] = '{4'b0011, {5'd0,  5'd0, 5'd7, 5'd0}, 0,  1};
    tbl[2] = '{4'b0000, {5'd1,  5'd1, 5'd1, 5'd1}, 0, -1};
    tbl[3] = '{4'b1111, {5'd0,  5'd0, 5'd0, 5'd0}, 0, -1};
    tbl[4] = '{4'b1111, {5'd1,  5'd1, 5'd1, 5'd1}, 0,  0};
    tbl[5] = '{4'b1000, {5'd31, 5'd0, 5'd0, 5'd0}, 3,  3};
    tbl[6] = '{4'b0110, {5'd0,  5'd5, 5'd0, 5'd9}, 5,  2};
    tbl[7] = '{4'b1010, {5'd2,  5'd0, 5'd4, 5'd0}, 1,  1};

    drive(1'b0, 1'b0, 4'h0, 20'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 20'h0, 1'b0);

    // Reset values
    do_reset();
    check("rst_gnt_val", 32'(a_gnt_val), 0);
    check("rst_gnt", 32'(a_gnt), 0);
    check("rst_gnt_idx", 32'(a_idx), 0);
    check("rst_req_rdy", 32'(a_rdy), 1);
    check("rst_req_rdy2", 32'(b_rdy), 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      xact(1'b0, tbl[i].req, tbl[i].wt, tbl[i].stall, tbl[i].exp_sel,
           $sformatf("tbl%0d", i), got);
    end

    // Single channel: every grant goes to channel 2
    do_reset();
    for (int i = 0; i < 9; i++)
      xact(1'b0, 4'b0100, {5'd0, 5'd3, 5'd0, 5'd0}, 0, 2, "single", got);

    // Stall on first grant must not double-decrement the credit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      e = model_commit(4, 4'b0011, {5'd0, 5'd0, 5'd1, 5'd2});
      xact(1'b0, 4'b0011, {5'd0, 5'd0, 5'd1, 5'd2}, (i == 0) ? 5 : 0, e, "stall", got);
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    do_reset();
    xact(1'b0, 4'b1000, {5'd1, 5'd0, 5'd0, 5'd0}, 0, 3, "pre_async", got);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt_val", 32'(a_gnt_val), 0);
    check("async_gnt", 32'(a_gnt), 0);
    check("async_gnt_idx", 32'(a_idx), 0);
    check("async_req_rdy", 32'(a_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // N=2, weights 4/2, 600 back-to-back requests
    do_reset();
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 600; i++) begin
      e = model_commit(2, 4'b0011, {10'd0, 5'd2, 5'd4});
      xact(1'b1, 4'b0011, {10'd0, 5'd2, 5'd4}, 0, e, "n2", got);
      if (i < 6) check($sformatf("n2_order%0d", i), 32'(got), 32'(exp6[i]));
      if (got >= 0) cnt[got]++;
    end
    check("n2_count0", 32'(cnt[0]), 400);
    check("n2_count1", 32'(cnt[1]), 200);

    // Mid-round reset restarts the sequence from channel 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = model_commit(2, 4'b0011, {10'd0, 5'd2, 5'd4});
      xact(1'b1, 4'b0011, {10'd0, 5'd2, 5'd4}, 0, e, "pre_mid", got);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      xact(1'b1, 4'b0011, {10'd0, 5'd2, 5'd4}, 0, exp6[i], $sformatf("restart%0d", i), got);
    end

    // Randomized requests, weights, and stalls against the model
    do_reset();
    w = '0;
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        for (int c = 0; c < 4; c++)
          w[c*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      end
      r = 4'($urandom);
      e = model_commit(4, r, w);
      xact(1'b0, r, w, (e >= 0) ? int'($urandom_range(0, 2)) : 0, e,
           $sformatf("rnd%0d", i), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
